goldschmidt_ctrl: RTL

GOLDSCHMIDT_CTRL -- requirements
Module: goldschmidt_ctrl

---
 rtl/gdiv_pkg.sv | 21 ++
 rtl/goldschmidt_ctrl_if.sv | 23 ++
 rtl/goldschmidt_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/gdiv_pkg.sv
// Shared types and constants for the Goldschmidt divider controller and its datapath.
package gdiv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_N0,
      ST_D0,
      ST_NI,
      ST_DI,
      ST_DONE
   } gdiv_state_e;

   // Multiplier operand select codes for sel_ND_mux
   localparam logic [1:0] SEL_N_IN  = 2'b00;
   localparam logic [1:0] SEL_D_IN  = 2'b01;
   localparam logic [1:0] SEL_REG_D = 2'b10;
   localparam logic [1:0] SEL_REG_N = 2'b11;

   localparam int ITERS_DEFAULT = 3;

endpackage

// File: rtl/goldschmidt_ctrl_if.sv
// Bundle of the controller's request/abort handshake and datapath control signals.
interface goldschmidt_ctrl_if;
   logic        start;
   logic        abort;
   logic [15:0] result_in;
   logic        load_regN;
   logic        load_regD;
   logic [1:0]  sel_ND_mux;
   logic        sel_K_mux;
   logic        busy;
   logic        done;
   logic [15:0] q_out;

   modport master (
      output start, abort, result_in,
      input  load_regN, load_regD, sel_ND_mux, sel_K_mux, busy, done, q_out
   );

   modport slave (
      input  start, abort, result_in,
      output load_regN, load_regD, sel_ND_mux, sel_K_mux, busy, done, q_out
   );
endinterface

// File: rtl/goldschmidt_ctrl.sv
// Sequencer for a Goldschmidt divider: one IA scaling pass, then ITERS
// refinement iterations, quotient captured from the datapath regN output.
//
// state | meaning
// IDLE  | waiting for start
// N0    | regN <= N * IA
// D0    | regD <= D * IA
// NI    | regN <= regN * (2 - regD), uses regD before this iteration updates it
// DI    | regD <= regD * (2 - regD), then loop or finish
// DONE  | one-cycle done pulse, q_out holds the quotient
module goldschmidt_ctrl
   import gdiv_pkg::*;
#(
   parameter int ITERS = ITERS_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] result_in,
   output logic        load_regN,
   output logic        load_regD,
   output logic [1:0]  sel_ND_mux,
   output logic        sel_K_mux,
   output logic        busy,
   output logic        done,
   output logic [15:0] q_out
);

   localparam logic [3:0] ITERS_LIM = 4'(ITERS);

   gdiv_state_e state, nxt;
   logic [2:0]  iter_cnt;
   logic [3:0]  iter_next;

   assign iter_next = {1'b0, iter_cnt} + 4'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         iter_cnt <= 3'd0;
         q_out    <= 16'h0000;
      end else begin
         state <= nxt;
         if (nxt == ST_N0)
            iter_cnt <= 3'd0;
         else if (state == ST_DI)
            iter_cnt <= iter_cnt + 3'd1;
         if (state == ST_DI && nxt == ST_DONE)
            q_out <= result_in;
      end
   end

   // abort overrides every transition out of a non-idle state
   always_comb begin
      nxt = state;
      if (state != ST_IDLE && abort) begin
         nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) nxt = ST_N0;
            ST_N0:   nxt = ST_D0;
            ST_D0:   nxt = ST_NI;
            ST_NI:   nxt = ST_DI;
            ST_DI:   nxt = (iter_next < ITERS_LIM) ? ST_NI : ST_DONE;
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      load_regN  = 1'b0;
      load_regD  = 1'b0;
      sel_ND_mux = SEL_N_IN;
      sel_K_mux  = 1'b1;
      busy       = (state != ST_IDLE);
      done       = 1'b0;
      case (state)
         ST_N0: begin
            load_regN = 1'b1;
         end
         ST_D0: begin
            sel_ND_mux = SEL_D_IN;
            load_regD  = 1'b1;
         end
         ST_NI: begin
            sel_ND_mux = SEL_REG_N;
            sel_K_mux  = 1'b0;
            load_regN  = 1'b1;
         end
         ST_DI: begin
            sel_ND_mux = SEL_REG_D;
            sel_K_mux  = 1'b0;
            load_regD  = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
